// File: rtl/vector_cpu_pkg.sv
// Shared sizes, opcodes and register selects for the vector_cpu block.
package vector_cpu_pkg;

    localparam int LANES     = 16;
    localparam int WORD      = 32;
    localparam int MEM_DEPTH = 512;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);
    localparam int VEC_W     = LANES * WORD;

    // Instruction opcodes; 101, 110 and 111 are no-ops.
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_INIT  = 3'b100;

    // Register selects; A4:A3 is the 64-bit-per-lane result pair.
    localparam logic [1:0] REG_A1 = 2'd0;
    localparam logic [1:0] REG_A2 = 2'd1;
    localparam logic [1:0] REG_A3 = 2'd2;
    localparam logic [1:0] REG_A4 = 2'd3;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_MUL = 1'b1
    } alu_op_e;

    typedef logic [WORD-1:0]   word_t;
    typedef logic [VEC_W-1:0]  vec_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/vector_lane_alu.sv
// One lane of the SIMD datapath: signed 32x32 add or multiply to 64 bits.
module vector_lane_alu
    import vector_cpu_pkg::*;
(
    input  logic signed [WORD-1:0]   operand_a,
    input  logic signed [WORD-1:0]   operand_b,
    input  alu_op_e                  op,
    output logic signed [2*WORD-1:0] result
);

    logic signed [2*WORD-1:0] a_ext;
    logic signed [2*WORD-1:0] b_ext;

    // Sign-extend both operands so the low 64 bits of either result are exact.
    always_comb begin
        a_ext  = {{WORD{operand_a[WORD-1]}}, operand_a};
        b_ext  = {{WORD{operand_b[WORD-1]}}, operand_b};
        result = (op == ALU_MUL) ? (a_ext * b_ext) : (a_ext + b_ext);
    end

endmodule

// File: rtl/vector_cpu.sv
// Single-cycle SIMD register file (A1..A4) plus 512x32 data memory.
module vector_cpu
    import vector_cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        instruction,
    input  logic [1:0]        reg_addr,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [VEC_W-1:0]  initialize_value,
    output logic [VEC_W-1:0]  A1_out,
    output logic [VEC_W-1:0]  A2_out,
    output logic [VEC_W-1:0]  A3_out,
    output logic [VEC_W-1:0]  A4_out
);

    vec_t              regs_q [4];
    vec_t              regs_d [4];
    word_t             mem_q  [MEM_DEPTH];
    addr_t             lane_addr  [LANES];
    logic [2*WORD-1:0] alu_result [LANES];
    alu_op_e           alu_op;
    logic              store_en;
    vec_t              store_data;

    assign alu_op     = (instruction == OP_MUL) ? ALU_MUL : ALU_ADD;
    assign store_en   = (instruction == OP_STORE);
    assign store_data = regs_q[reg_addr];

    // Per-lane word address; 9-bit addition wraps modulo the memory depth.
    // The 16 lane ALUs always work on A1/A2; the result is used only for ADD/MUL.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_addr[g] = mem_address + ADDR_W'(g);

        vector_lane_alu u_alu (
            .operand_a (regs_q[REG_A1][g*WORD +: WORD]),
            .operand_b (regs_q[REG_A2][g*WORD +: WORD]),
            .op        (alu_op),
            .result    (alu_result[g])
        );
    end

    // Next-state of the register file for the current instruction.
    always_comb begin
        // NOTE: copy the current state first so every path assigns regs_d (no latch).
        for (int r = 0; r < 4; r++) regs_d[r] = regs_q[r];
        case (instruction)
            OP_LOAD: begin
                for (int i = 0; i < LANES; i++)
                    regs_d[reg_addr][i*WORD +: WORD] = mem_q[lane_addr[i]];
            end
            OP_ADD, OP_MUL: begin
                for (int i = 0; i < LANES; i++) begin
                    regs_d[REG_A3][i*WORD +: WORD] = alu_result[i][WORD-1:0];
                    regs_d[REG_A4][i*WORD +: WORD] = alu_result[i][2*WORD-1:WORD];
                end
            end
            OP_INIT: regs_d[reg_addr] = initialize_value;
            default: ;
        endcase
    end

    // Register file update with synchronous clear.
    always_ff @(posedge clk) begin
        for (int r = 0; r < 4; r++) begin
            if (rst) regs_q[r] <= '0;
            else     regs_q[r] <= regs_d[r];
        end
    end

    // Data memory: 16-word store per STORE, whole array cleared on reset.
    // NOTE: the memory is reset on purpose because reset must zero every word;
    // this keeps it as flops rather than an inferred RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < MEM_DEPTH; w++) mem_q[w] <= '0;
        end else if (store_en) begin
            for (int i = 0; i < LANES; i++)
                mem_q[lane_addr[i]] <= store_data[i*WORD +: WORD];
        end
    end

    assign A1_out = regs_q[REG_A1];
    assign A2_out = regs_q[REG_A2];
    assign A3_out = regs_q[REG_A3];
    assign A4_out = regs_q[REG_A4];

endmodule

// File: tb/tb_vector_cpu.sv
// Scoreboard bench for vector_cpu: the driver queues hand-computed lane or
// vector expectations for each edge, a monitor compares them after that edge.
module tb_vector_cpu;
    import vector_cpu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   instruction;
    logic [1:0]   reg_addr;
    logic [8:0]   mem_address;
    logic [511:0] initialize_value;
    logic [511:0] a1_out, a2_out, a3_out, a4_out;

    vector_cpu dut (
        .clk              (clk),
        .rst              (rst),
        .instruction      (instruction),
        .reg_addr         (reg_addr),
        .mem_address      (mem_address),
        .initialize_value (initialize_value),
        .A1_out           (a1_out),
        .A2_out           (a2_out),
        .A3_out           (a3_out),
        .A4_out           (a4_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        int           r;     // 0..3 = A1..A4
        int           lane;  // -1 = whole 512-bit vector
        logic [511:0] exp;
        int           when;  // edge count after which to compare
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [511:0] dut_reg(input int r);
        case (r)
            0:       return a1_out;
            1:       return a2_out;
            2:       return a3_out;
            default: return a4_out;
        endcase
    endfunction

    // Monitor: after every edge, compare all expectations due at that edge.
    initial begin
        exp_t         e;
        logic [511:0] got;
        logic [511:0] want;
        forever begin
            @(posedge clk);
            #1;
            while (sb.size() > 0 && sb[0].when <= cyc) begin
                e = sb.pop_front();
                if (e.lane < 0) begin
                    got  = dut_reg(e.r);
                    want = e.exp;
                end else begin
                    got  = {480'b0, dut_reg(e.r)[e.lane*32 +: 32]};
                    want = {480'b0, e.exp[31:0]};
                end
                checks++;
                if (e.when != cyc || got !== want) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h (edge %0d due %0d)",
                             e.name, got, want, cyc, e.when);
                end
            end
        end
    end

    // Drive one instruction for the next rising edge.
    task automatic issue(input logic [2:0] op, input logic [1:0] ra, input logic [8:0] ad,
                         input logic [511:0] iv, input logic r);
        @(negedge clk);
        rst              = r;
        instruction      = op;
        reg_addr         = ra;
        mem_address      = ad;
        initialize_value = iv;
    endtask

    task automatic exp_lane(input string n, input int r, input int lane, input logic [31:0] v);
        exp_t e;
        e.name = n; e.r = r; e.lane = lane; e.exp = {480'b0, v}; e.when = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic exp_vec(input string n, input int r, input logic [511:0] v);
        exp_t e;
        e.name = n; e.r = r; e.lane = -1; e.exp = v; e.when = cyc + 1;
        sb.push_back(e);
    endtask

    logic [511:0] v1, v2, v1x2, v4, b1, b2, va4, junk;
    logic [511:0] pat [4];
    int           v4_vals [16] = '{-1, 2, 3, -5, 5, 6, 7, 8, 9, 10, 11, 12, 13, -14, 15, -1048576};

    initial begin
        rst = 1'b1; instruction = 3'b111; reg_addr = 2'd0; mem_address = 9'd0; initialize_value = '0;
        junk = {16{32'hDEAD_BEEF}};
        v1 = '0; v2 = '0; v1x2 = '0; v4 = '0; b1 = '0; b2 = '0; va4 = '0;
        for (int i = 0; i < 16; i++) begin
            v1[i*32 +: 32]   = 32'(i + 1);
            v1x2[i*32 +: 32] = 32'(2 * (i + 1));
            v4[i*32 +: 32]   = v4_vals[i];
            va4[i*32 +: 32]  = 32'hA000_0000 + 32'(i);
            if (i < 8) v2[i*32 +: 32] = 32'(1) << i;
            for (int r = 0; r < 4; r++)
                pat[r][i*32 +: 32] = (32'(r + 1) << 24) | (32'(i) << 8) | 32'h5A;
        end
        v1[15*32 +: 32]   = 32'h0010_0000;
        v1x2[15*32 +: 32] = 32'h0020_0000;
        b1[31:0] = 32'h7FFF_FFFF; b1[63:32] = 32'h8000_0000;
        b2[31:0] = 32'h0000_0001; b2[63:32] = 32'h8000_0000;

        // Reset state
        issue(3'b111, 2'd0, 9'd0, '0, 1'b1);
        issue(3'b111, 2'd0, 9'd0, junk, 1'b1);
        exp_vec("rst_a1", 0, '0); exp_vec("rst_a2", 1, '0);
        exp_vec("rst_a3", 2, '0); exp_vec("rst_a4", 3, '0);

        // INIT A1
        issue(OP_INIT, REG_A1, 9'd0, v1, 1'b0);
        exp_lane("init_a1_l0", 0, 0, 32'd1);
        exp_lane("init_a1_l14", 0, 14, 32'd15);
        exp_lane("init_a1_l15", 0, 15, 32'h0010_0000);
        exp_vec("init_a2_zero", 1, '0); exp_vec("init_a3_zero", 2, '0); exp_vec("init_a4_zero", 3, '0);

        // INIT A2 powers of two, MUL then ADD
        issue(OP_INIT, REG_A2, 9'd0, v2, 1'b0);
        exp_lane("init_a2_l7", 1, 7, 32'd128);
        exp_lane("init_a2_l8", 1, 8, 32'd0);
        issue(OP_MUL, 2'd3, 9'h1FF, junk, 1'b0);
        exp_lane("mul1_a3_l0", 2, 0, 32'd1);
        exp_lane("mul1_a3_l3", 2, 3, 32'd32);
        exp_lane("mul1_a3_l7", 2, 7, 32'd1024);
        exp_lane("mul1_a3_l8", 2, 8, 32'd0);
        exp_vec("mul1_a4", 3, '0);
        issue(OP_ADD, 2'd0, 9'd77, junk, 1'b0);
        exp_lane("add1_a3_l0", 2, 0, 32'd2);
        exp_lane("add1_a3_l7", 2, 7, 32'd136);
        exp_lane("add1_a3_l8", 2, 8, 32'd9);
        exp_lane("add1_a3_l15", 2, 15, 32'h0010_0000);
        exp_vec("add1_a4", 3, '0);

        // Store/load round trips
        issue(OP_STORE, REG_A1, 9'd10, junk, 1'b0);
        exp_vec("st_a1_hold", 0, v1);
        exp_lane("st_a3_hold", 2, 7, 32'd136);
        issue(OP_LOAD, REG_A2, 9'd10, junk, 1'b0);
        exp_vec("ld_a2_eq_a1", 1, v1);
        issue(OP_ADD, 2'd1, 9'd0, junk, 1'b0);
        exp_vec("add2_a3", 2, v1x2);
        exp_vec("add2_a4", 3, '0);
        issue(OP_STORE, REG_A3, 9'd26, junk, 1'b0);
        issue(OP_LOAD, REG_A1, 9'd26, junk, 1'b0);
        exp_lane("ld26_a1_l0", 0, 0, 32'd2);
        exp_lane("ld26_a1_l15", 0, 15, 32'h0020_0000);
        issue(OP_LOAD, REG_A3, 9'd18, junk, 1'b0);
        exp_lane("ld18_a3_l0", 2, 0, 32'd9);
        exp_lane("ld18_a3_l7", 2, 7, 32'h0010_0000);
        exp_lane("ld18_a3_l8", 2, 8, 32'd2);
        exp_lane("ld18_a3_l15", 2, 15, 32'd16);

        // Signed MUL/ADD with A1 = 2*(i+1)
        issue(OP_INIT, REG_A2, 9'd0, v4, 1'b0);
        issue(OP_MUL, 2'd0, 9'd0, junk, 1'b0);
        exp_lane("smul_a3_l0", 2, 0, 32'hFFFF_FFFE);
        exp_lane("smul_a4_l0", 3, 0, 32'hFFFF_FFFF);
        exp_lane("smul_a3_l3", 2, 3, 32'hFFFF_FFD8);
        exp_lane("smul_a4_l3", 3, 3, 32'hFFFF_FFFF);
        exp_lane("smul_a3_l13", 2, 13, 32'hFFFF_FE78);
        exp_lane("smul_a3_l14", 2, 14, 32'h0000_01C2);
        exp_lane("smul_a4_l14", 3, 14, 32'h0000_0000);
        exp_lane("smul_a3_l15", 2, 15, 32'h0000_0000);
        exp_lane("smul_a4_l15", 3, 15, 32'hFFFF_FE00);
        issue(OP_ADD, 2'd0, 9'd0, junk, 1'b0);
        exp_lane("sadd_a3_l0", 2, 0, 32'd1);
        exp_lane("sadd_a4_l0", 3, 0, 32'd0);
        exp_lane("sadd_a3_l3", 2, 3, 32'd3);
        exp_lane("sadd_a4_l3", 3, 3, 32'd0);
        exp_lane("sadd_a3_l13", 2, 13, 32'd14);
        exp_lane("sadd_a3_l15", 2, 15, 32'h0010_0000);
        exp_lane("sadd_a4_l15", 3, 15, 32'd0);

        // Extreme operands
        issue(OP_INIT, REG_A1, 9'd0, b1, 1'b0);
        issue(OP_INIT, REG_A2, 9'd0, b2, 1'b0);
        issue(OP_ADD, 2'd0, 9'd0, junk, 1'b0);
        exp_lane("max_add_a3_l0", 2, 0, 32'h8000_0000);
        exp_lane("max_add_a4_l0", 3, 0, 32'h0000_0000);
        exp_lane("min_add_a3_l1", 2, 1, 32'h0000_0000);
        exp_lane("min_add_a4_l1", 3, 1, 32'hFFFF_FFFF);
        exp_lane("zero_add_a3_l2", 2, 2, 32'h0000_0000);
        issue(OP_MUL, 2'd0, 9'd0, junk, 1'b0);
        exp_lane("max_mul_a3_l0", 2, 0, 32'h7FFF_FFFF);
        exp_lane("max_mul_a4_l0", 3, 0, 32'h0000_0000);
        exp_lane("min_mul_a3_l1", 2, 1, 32'h0000_0000);
        exp_lane("min_mul_a4_l1", 3, 1, 32'h4000_0000);

        // Address wrap on store and load
        issue(OP_INIT, REG_A4, 9'd0, va4, 1'b0);
        issue(OP_STORE, REG_A4, 9'd510, junk, 1'b0);
        issue(OP_LOAD, REG_A2, 9'd0, junk, 1'b0);
        exp_lane("wrap_ld0_l0", 1, 0, 32'hA000_0002);
        exp_lane("wrap_ld0_l13", 1, 13, 32'hA000_000F);
        exp_lane("wrap_ld0_l14", 1, 14, 32'd5);
        exp_lane("wrap_ld0_l15", 1, 15, 32'd6);
        issue(OP_LOAD, REG_A3, 9'd508, junk, 1'b0);
        exp_lane("wrap_ld508_l0", 2, 0, 32'd0);
        exp_lane("wrap_ld508_l2", 2, 2, 32'hA000_0000);
        exp_lane("wrap_ld508_l3", 2, 3, 32'hA000_0001);
        exp_lane("wrap_ld508_l15", 2, 15, 32'hA000_000D);

        // No-op opcodes hold registers and memory
        for (int r = 0; r < 4; r++) issue(OP_INIT, 2'(r), 9'd0, pat[r], 1'b0);
        exp_vec("init_a4_pat", 3, pat[3]);
        issue(3'b101, REG_A1, 9'd0, junk, 1'b0);
        exp_vec("nop5_a1", 0, pat[0]);
        issue(3'b110, REG_A2, 9'd0, junk, 1'b0);
        exp_vec("nop6_a2", 1, pat[1]);
        issue(3'b111, REG_A3, 9'd0, junk, 1'b0);
        exp_vec("nop7_a1", 0, pat[0]); exp_vec("nop7_a2", 1, pat[1]);
        exp_vec("nop7_a3", 2, pat[2]); exp_vec("nop7_a4", 3, pat[3]);
        issue(OP_LOAD, REG_A1, 9'd0, junk, 1'b0);
        exp_lane("nop_mem_hold", 0, 0, 32'hA000_0002);

        // Reset overrides INIT and clears memory
        issue(OP_INIT, REG_A1, 9'd0, pat[3], 1'b1);
        exp_vec("rst2_a1", 0, '0); exp_vec("rst2_a2", 1, '0);
        exp_vec("rst2_a3", 2, '0); exp_vec("rst2_a4", 3, '0);
        issue(OP_LOAD, REG_A1, 9'd10, junk, 1'b0);
        exp_vec("rst2_ld10", 0, '0);
        issue(OP_LOAD, REG_A2, 9'd510, junk, 1'b0);
        exp_vec("rst2_ld510", 1, '0);
        issue(3'b111, 2'd0, 9'd0, '0, 1'b0);

        // Bounded drain of the scoreboard
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
